exe_muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the EXE stage.
- Consumes the operands, index and instruction fields held in the ID/EXE pipeline register.
- Holds the front of the pipeline via stall_o while it computes.
- Returns a 32-bit result with a one-cycle done pulse, so the EXE/MEM register captures it on the cycle the stall drops.

---
 rtl/exe_muldiv_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : exe_muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the EXE stage.
//               Radix-2 shift-add multiply and restoring divide on operand
//               magnitudes. Sign correction happens in a final FIX cycle.
//               Latency is fixed at 33 cycles from accept to done.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [XLEN-1:0] rt_data_i,
    input  logic [4:0]      rd_index_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_index_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(XLEN - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, quotient}.
    logic [2*XLEN-1:0] r_acc;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [XLEN-1:0]   r_opnd;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic              r_neg_a;
    logic              r_neg_b;
    logic              r_div0;

    // Operand decode at accept time
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_accept;

    // One iteration step
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_rem;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_step;

    // Sign correction and result select
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    // MUL, MULH, MULHSU, DIV, REM treat A as signed; MULHSU treats B as unsigned.
    assign w_a_signed = (funct3_i == 3'd0) || (funct3_i == 3'd1) || (funct3_i == 3'd2)
                     || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    assign w_b_signed = (funct3_i == 3'd0) || (funct3_i == 3'd1)
                     || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    assign w_neg_a    = w_a_signed & rs_data_i[XLEN-1];
    assign w_neg_b    = w_b_signed & rt_data_i[XLEN-1];
    assign w_a_mag    = w_neg_a ? (-rs_data_i) : rs_data_i;
    assign w_b_mag    = w_neg_b ? (-rt_data_i) : rt_data_i;

    // The done guard keeps the just-completed instruction, still sitting in
    // ID/EXE during its done cycle, from being taken a second time.
    assign w_accept   = (r_state == c_IDLE) && valid_i && !done_o;

    // Shift-add multiply: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. The remainder always stays below
    // the divisor, so the truncated subtraction is exact.
    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_rem   = w_div_ge ? (w_div_shift[XLEN-1:0] - r_opnd) : w_div_shift[XLEN-1:0];
    assign w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};

    assign w_step      = r_funct3[2] ? w_div_next : w_mul_next;

    // Divide by zero naturally yields remainder = |A| (restored to A by the
    // dividend sign fix) but the quotient must be forced to all ones.
    assign w_prod = (r_neg_a ^ r_neg_b) ? (-r_acc) : r_acc;
    assign w_quot = r_div0 ? {XLEN{1'b1}}
                  : ((r_neg_a ^ r_neg_b) ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0]);
    assign w_rem  = r_neg_a ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

    // Final result selection by operation
    always_comb begin
        w_result = w_prod[XLEN-1:0];
        case (r_funct3)
            3'd0:          w_result = w_prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          w_result = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:    w_result = w_quot;
            default:       w_result = w_rem;
        endcase
    end

    assign busy_o  = (r_state == c_CALC);
    assign stall_o = busy_o | (r_state == c_FIX) | w_accept;

    // Sequencer: accept, iterate 32 steps, then sign-fix and publish the result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_funct3   <= '0;
            r_rd       <= '0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_div0     <= 1'b0;
            result_o   <= '0;
            rd_index_o <= '0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state  <= c_CALC;
                        r_cnt    <= '0;
                        r_funct3 <= funct3_i;
                        r_rd     <= rd_index_i;
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_div0   <= (rt_data_i == '0);
                        r_opnd   <= funct3_i[2] ? w_b_mag : w_a_mag;
                        r_acc    <= {{XLEN{1'b0}}, (funct3_i[2] ? w_a_mag : w_b_mag)};
                    end
                end
                c_CALC: begin
                    if (flush_i) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST_STEP) begin
                            r_state <= c_FIX;
                        end
                    end
                end
                c_FIX: begin
                    r_state <= c_IDLE;
                    if (!flush_i) begin
                        result_o   <= w_result;
                        rd_index_o <= r_rd;
                        done_o     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
